// File: rtl/itof_converter.sv
// itof_converter
//   Multi-cycle signed two's-complement integer to IEEE-754 single-precision
//   converter. A captured sample is normalised by shifting left one bit per
//   cycle until its MSB is set, then rounded (round to nearest, ties to even)
//   when the sample is wider than the 24-bit float mantissa.
//
//   Ports:
//     clk              rising-edge clock
//     rst              synchronous, active-high reset
//     sample_valid     request conversion of sample_data_in (taken only in IDLE)
//     sample_data_in   signed sample, data_width bits
//     float_data_out   IEEE-754 result, held until the next done
//     ItoF_done        1-cycle pulse, float_data_out valid this cycle
//     ItoF_idle        high while ready to accept a sample
//     ItoF_processing  high while a conversion is in flight (NORM/ROUND/DONE)
//     ItoF_overrun     1-cycle pulse, a sample offered while busy was dropped
//
//   Parameters:
//     data_width  sample width, 2..32
//     fp_width    output width, must be 32
//     exp_bias    IEEE exponent bias
module itof_converter #(
  parameter int data_width = 24,
  parameter int fp_width   = 32,
  parameter int exp_bias   = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [data_width-1:0] sample_data_in,
  output logic [fp_width-1:0]   float_data_out,
  output logic                  ItoF_done,
  output logic                  ItoF_idle,
  output logic                  ItoF_processing,
  output logic                  ItoF_overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exponent of an unshifted sample: its MSB position is data_width-1.
  localparam logic [8:0] EXP_INIT = 9'(exp_bias + data_width - 1);

  state_t                state_q, state_d;
  logic                  sign_q;
  logic [data_width-1:0] mag_q;
  logic [8:0]            exp_q;

  logic [data_width-1:0] mag_in;
  logic                  mag_zero;
  logic                  mag_top;

  // Rounding datapath
  logic [31:0]           mag_al;
  logic                  lsb, guard, sticky, round_up;
  logic [24:0]           mant_rnd;
  logic [8:0]            exp_rnd;
  logic [22:0]           frac_rnd;

  // Magnitude as unsigned data_width bits; the most negative sample maps to
  // 2^(data_width-1), which still fits.
  assign mag_in   = sample_data_in[data_width-1] ? (~sample_data_in + 1'b1)
                                                 : sample_data_in;
  assign mag_zero = (mag_q == '0);
  assign mag_top  = mag_q[data_width-1];

  // ---------------------------------------------------------------------------
  // State register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (sample_valid) state_d = NORM;
      NORM: begin
        if (mag_zero)     state_d = DONE;
        else if (mag_top) state_d = ROUND;
      end
      ROUND: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Rounding
  // The normalised magnitude is left-aligned into 32 bits so one rounding
  // path covers every width: for data_width <= 24 the bits below the kept
  // 24 are all zero, so guard and sticky are zero and the result is exact.
  // ---------------------------------------------------------------------------
  always_comb begin
    mag_al   = 32'(mag_q) << (32 - data_width);
    lsb      = mag_al[8];
    guard    = mag_al[7];
    sticky   = |mag_al[6:0];
    round_up = guard & (sticky | lsb);
    mant_rnd = {1'b0, mag_al[31:8]} + 25'(round_up);
    exp_rnd  = exp_q;
    frac_rnd = mant_rnd[22:0];
    // 1.111..1 rounded up becomes 10.000..0: renormalise to 1.0, bump exp.
    if (mant_rnd[24]) begin
      exp_rnd  = exp_q + 9'd1;
      frac_rnd = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q         <= 1'b0;
      mag_q          <= '0;
      exp_q          <= '0;
      float_data_out <= '0;
      ItoF_done      <= 1'b0;
      ItoF_overrun   <= 1'b0;
    end else begin
      ItoF_done    <= 1'b0;
      // Any offer outside IDLE is dropped and flagged one cycle later.
      ItoF_overrun <= sample_valid && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            sign_q <= sample_data_in[data_width-1];
            mag_q  <= mag_in;
            exp_q  <= EXP_INIT;
          end
        end
        NORM: begin
          if (mag_zero) begin
            // Zero never reaches ROUND; result is always +0.
            float_data_out <= '0;
            ItoF_done      <= 1'b1;
          end else if (!mag_top) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 9'd1;
          end
        end
        ROUND: begin
          float_data_out <= fp_width'({sign_q, exp_rnd[7:0], frac_rnd});
          ItoF_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status flags decode the registered state only.
  assign ItoF_idle       = (state_q == IDLE);
  assign ItoF_processing = (state_q != IDLE);

endmodule

// File: tb/tb_itof_converter.sv
module tb_itof_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v24, v32;
  logic [23:0] d24;
  logic [31:0] d32;
  logic [31:0] o24, o32;
  logic        done24, idle24, proc24, ovr24;
  logic        done32, idle32, proc32, ovr32;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  itof_converter #(.data_width(24), .fp_width(32), .exp_bias(127)) dut24 (
    .clk(clk), .rst(rst), .sample_valid(v24), .sample_data_in(d24),
    .float_data_out(o24), .ItoF_done(done24), .ItoF_idle(idle24),
    .ItoF_processing(proc24), .ItoF_overrun(ovr24)
  );

  itof_converter #(.data_width(32), .fp_width(32), .exp_bias(127)) dut32 (
    .clk(clk), .rst(rst), .sample_valid(v32), .sample_data_in(d32),
    .float_data_out(o32), .ItoF_done(done32), .ItoF_idle(idle32),
    .ItoF_processing(proc32), .ItoF_overrun(ovr32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: go through double precision (exact for any 32-bit integer),
  // then round the 53-bit significand to 24 bits, nearest-even.
  function automatic logic [31:0] ref_float(input longint v);
    logic [63:0] b;
    logic [52:0] m;
    logic [24:0] keep;
    logic        g, st;
    int          e;
    if (v == 0) return 32'h0;
    b    = $realtobits(real'(v));
    e    = int'(b[62:52]) - 1023 + 127;
    m    = {1'b1, b[51:0]};
    keep = {1'b0, m[52:29]};
    g    = m[28];
    st   = |m[27:0];
    if (g && (st || keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      e    = e + 1;
      keep = 25'h0800000;
    end
    return {b[63], 8'(e), keep[22:0]};
  endfunction

  function automatic int ref_lat(input longint v, input int w);
    longint a;
    int     msb;
    a   = (v < 0) ? -v : v;
    msb = -1;
    if (a == 0) return 2;
    for (int i = 0; i < w; i++) if (a[i]) msb = i;
    return (w - 1 - msb) + 3;
  endfunction

  // Drive one sample into the selected instance, then check latency, value
  // and that done is a single-cycle pulse followed by IDLE.
  task automatic conv(input bit wide, input longint v, input string tag);
    int          lat, k;
    bit          seen;
    logic [31:0] obs, exp;
    exp  = ref_float(v);
    lat  = ref_lat(v, wide ? 32 : 24);
    obs  = 'x;
    seen = 1'b0;
    k    = 0;
    @(negedge clk);
    if (wide) begin v32 = 1'b1; d32 = v[31:0]; end
    else      begin v24 = 1'b1; d24 = v[23:0]; end
    @(posedge clk);
    #1 v24 = 1'b0; v32 = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (wide ? done32 : done24) begin
        seen = 1'b1;
        k    = i;
        obs  = wide ? o32 : o24;
      end
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " value"}, obs, exp);
    @(negedge clk);
    check({tag, " pulse"}, wide ? {30'b0, done32, idle32} : {30'b0, done24, idle24}, 32'h1);
  endtask

  initial begin : stim
    longint     samp [3];
    longint     x;
    int         ncap, ndone;
    bit         seen;

    rst = 1'b1; v24 = 1'b0; v32 = 1'b0; d24 = '0; d32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out24", o24, 32'h0);
    check("reset out32", o32, 32'h0);
    check("reset flags24", {28'b0, done24, ovr24, idle24, proc24}, 32'h2);
    check("reset flags32", {28'b0, done32, ovr32, idle32, proc32}, 32'h2);
    rst = 1'b0;

    // Directed vectors, 24-bit
    conv(0, 1,        "w24 one");
    conv(0, -1,       "w24 minus_one");
    conv(0, -8388608, "w24 most_neg");
    conv(0, 8388607,  "w24 most_pos");
    conv(0, 0,        "w24 zero");
    check("w24 one abs", 32'(ref_float(1)), 32'h3F800000);

    // Directed vectors, 32-bit rounding corners
    conv(1, 64'sh7FFFFFFF,   "w32 carry");
    conv(1, 64'sh01000001,   "w32 tie_even");
    conv(1, 64'sh01000003,   "w32 tie_up");
    conv(1, -64'sh80000000,  "w32 most_neg");
    conv(1, 0,               "w32 zero");
    conv(1, 2,               "w32 two");

    // Random, with varied leading-zero counts and both signs
    for (int n = 0; n < 30; n++) begin
      x = longint'($signed(24'($urandom)));
      x = x >>> $urandom_range(0, 23);
      conv(0, x, "w24 rand");
    end
    for (int n = 0; n < 30; n++) begin
      x = longint'($signed(32'($urandom)));
      x = x >>> $urandom_range(0, 31);
      conv(1, x, "w32 rand");
    end

    // Overrun during NORM and during the DONE cycle
    @(negedge clk);
    v24 = 1'b1; d24 = 24'd1;
    @(posedge clk);
    #1 v24 = 1'b0;
    @(negedge clk);
    check("ovr busy flags", {30'b0, proc24, idle24}, 32'h2);
    v24 = 1'b1; d24 = 24'h123456;
    @(posedge clk);
    #1 v24 = 1'b0;
    @(negedge clk);
    check("ovr norm pulse", {31'b0, ovr24}, 32'h1);
    @(negedge clk);
    check("ovr norm clear", {31'b0, ovr24}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done24) seen = 1'b1;
    end
    check("ovr done seen", {31'b0, seen}, 32'h1);
    check("ovr first value", o24, 32'h3F800000);
    v24 = 1'b1; d24 = 24'h7FFFFF;
    @(posedge clk);
    #1 v24 = 1'b0;
    @(negedge clk);
    check("ovr done pulse", {29'b0, ovr24, idle24, done24}, 32'h6);
    check("ovr held value", o24, 32'h3F800000);
    @(negedge clk);
    check("ovr not captured", {30'b0, idle24, proc24}, 32'h2);

    // Valid held high for three samples
    samp[0] = 3; samp[1] = -7; samp[2] = 0;
    ncap = 0; ndone = 0;
    for (int i = 0; i < 300 && ndone < 3; i++) begin
      @(negedge clk);
      if (done24) begin
        check("held value", o24, ref_float(samp[ndone]));
        ndone++;
      end
      if (idle24) begin
        if (ncap < 3) begin
          d24 = samp[ncap][23:0];
          v24 = 1'b1;
          ncap++;
        end else v24 = 1'b0;
      end
    end
    v24 = 1'b0;
    check("held done count", 32'(ndone), 32'd3);

    // Reset mid-NORM aborts the conversion
    @(negedge clk);
    @(negedge clk);
    v24 = 1'b1; d24 = 24'd1;
    @(posedge clk);
    #1 v24 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst flags", {29'b0, idle24, done24, proc24}, 32'h4);
    check("rst out", o24, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done24) seen = 1'b1;
    end
    check("rst no done", {31'b0, seen}, 32'h0);
    conv(0, -5, "w24 post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
